// File: rtl/register_bank_pkg.sv
// Shared defaults for the register bank and its operand scoreboard, plus
// slice helpers for the ascending, port-0-leftmost flattened buses.
`define RB_LO(k, w) ((k) * (w))
`define RB_SLICE(k, w) `RB_LO(k, w) +: (w)

package register_bank_pkg;
  localparam int DEF_ADDRESS_SIZE  = 5;
  localparam int DEF_REGISTER_SIZE = 8;
  localparam int DEF_READ_PORTS    = 2;
  localparam int DEF_ZERO_REG      = 1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending bits: operand ready flags, write-after-write detect and
// a registered count of outstanding producers.
module register_scoreboard
  import register_bank_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int READ_PORTS   = DEF_READ_PORTS,
  parameter int ZERO_REG     = DEF_ZERO_REG
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 write,
  input  logic [ADDRESS_SIZE-1:0]              addr_in,
  input  logic                                 reserve,
  input  logic [ADDRESS_SIZE-1:0]              addr_rsv,
  input  logic                                 flush,
  input  logic [0:READ_PORTS*ADDRESS_SIZE-1]   addr_out,
  output logic [0:READ_PORTS-1]                ready,
  output logic [ADDRESS_SIZE:0]                busy_count,
  output logic                                 waw
);
  localparam int DEPTH = depth_of(ADDRESS_SIZE);

  logic [DEPTH-1:0]      pend, pend_nxt, clr_mask, set_mask;
  logic [ADDRESS_SIZE:0] cnt_nxt;
  logic                  rsv_ok, same, inc, dec;

  assign rsv_ok = reserve && !(ZERO_REG != 0 && addr_rsv == '0);
  assign same   = write && (addr_in == addr_rsv);
  assign waw    = rsv_ok && pend[addr_rsv] && !same;

  // inc/dec track the popcount delta; a same-address write+reserve nets zero.
  assign inc = rsv_ok && !pend[addr_rsv];
  assign dec = write && pend[addr_in] && !(rsv_ok && same);

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (write)  clr_mask = DEPTH'(1) << addr_in;
    if (rsv_ok) set_mask = DEPTH'(1) << addr_rsv;
    pend_nxt = ((flush ? '0 : pend) & ~clr_mask) | set_mask;
    if (flush) cnt_nxt = (ADDRESS_SIZE+1)'(rsv_ok);
    else       cnt_nxt = busy_count + (ADDRESS_SIZE+1)'(inc) - (ADDRESS_SIZE+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend       <= '0;
      busy_count <= '0;
    end else begin
      pend       <= pend_nxt;
      busy_count <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rdy
    logic [ADDRESS_SIZE-1:0] ra;
    assign ra       = addr_out[`RB_SLICE(k, ADDRESS_SIZE)];
    assign ready[k] = !pend[ra] || (write && addr_in == ra);
  end
endmodule

// File: rtl/register_bank_sb.sv
// Multi-ported register file with write-through bypass and an operand
// scoreboard; register 0 optionally reads as a constant zero.
module register_bank_sb
  import register_bank_pkg::*;
#(
  parameter int ADDRESS_SIZE  = DEF_ADDRESS_SIZE,
  parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
  parameter int READ_PORTS    = DEF_READ_PORTS,
  parameter int ZERO_REG      = DEF_ZERO_REG
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 write,
  input  logic [ADDRESS_SIZE-1:0]              addr_in,
  input  logic [REGISTER_SIZE-1:0]             data_in,
  input  logic [0:READ_PORTS*ADDRESS_SIZE-1]   addr_out,
  output logic [0:READ_PORTS*REGISTER_SIZE-1]  data_out,
  output logic [0:READ_PORTS-1]                ready,
  input  logic                                 reserve,
  input  logic [ADDRESS_SIZE-1:0]              addr_rsv,
  input  logic                                 flush,
  output logic [ADDRESS_SIZE:0]                busy_count,
  output logic                                 waw
);
  localparam int DEPTH = depth_of(ADDRESS_SIZE);

  logic [REGISTER_SIZE-1:0] mem [DEPTH];
  logic                     wr_ok;

  // Writes to a hardwired zero register are dropped, so it never bypasses either.
  assign wr_ok = write && !(ZERO_REG != 0 && addr_in == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[addr_in] <= data_in;
    end
  end

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [ADDRESS_SIZE-1:0] ra;
    assign ra = addr_out[`RB_SLICE(k, ADDRESS_SIZE)];
    assign data_out[`RB_SLICE(k, REGISTER_SIZE)] = (wr_ok && addr_in == ra) ? data_in : mem[ra];
  end

  register_scoreboard #(
    .ADDRESS_SIZE(ADDRESS_SIZE),
    .READ_PORTS  (READ_PORTS),
    .ZERO_REG    (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .write     (write),
    .addr_in   (addr_in),
    .reserve   (reserve),
    .addr_rsv  (addr_rsv),
    .flush     (flush),
    .addr_out  (addr_out),
    .ready     (ready),
    .busy_count(busy_count),
    .waw       (waw)
  );
endmodule

// File: tb/tb_register_bank_sb.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a negedge monitor
// pops and compares them against the DUT.
module tb_register_bank_sb;
  logic        clk = 1'b0;
  logic        reset, write, reserve, flush;
  logic [4:0]  addr_in, addr_rsv;
  logic [7:0]  data_in;
  logic [0:9]  addr_out;
  logic [0:15] data_out;
  logic [0:1]  ready;
  logic [5:0]  busy_count;
  logic        waw;

  register_bank_sb #(.ADDRESS_SIZE(5), .REGISTER_SIZE(8), .READ_PORTS(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .write(write), .addr_in(addr_in), .data_in(data_in),
    .addr_out(addr_out), .data_out(data_out), .ready(ready), .reserve(reserve),
    .addr_rsv(addr_rsv), .flush(flush), .busy_count(busy_count), .waw(waw)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d0, d1;
    logic       r0, r1;
    logic       waw;
    logic [5:0] busy;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: the architectural registers and which ones await a producer.
  int unsigned mem_m  [32];
  bit          pend_m [32];

  task automatic cmp(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      logic [15:0] d;
      logic [1:0]  r;
      e = expq.pop_front();
      d = data_out;
      r = ready;
      cmp("data_out0", int'(d[15:8]), int'(e.d0));
      cmp("data_out1", int'(d[7:0]),  int'(e.d1));
      cmp("ready0",    int'(r[1]),    int'(e.r0));
      cmp("ready1",    int'(r[0]),    int'(e.r1));
      cmp("waw",       int'(waw),     int'(e.waw));
      cmp("busy_count", int'(busy_count), int'(e.busy));
    end
  end

  function automatic int unsigned rd_m(input int a, input bit wr, input int ai, input int di);
    if (a == 0) return 0;
    if (wr && ai == a) return di;
    return mem_m[a];
  endfunction

  task automatic step(input bit rst, input bit wr, input int ai, input int di,
                      input int a0, input int a1, input bit rs, input int ar,
                      input bit fl, input bit chk = 1'b1);
    exp_t e;
    int   cnt;
    @(posedge clk);
    #1;
    reset = rst; write = wr; addr_in = 5'(ai); data_in = 8'(di);
    addr_out = {5'(a0), 5'(a1)}; reserve = rs; addr_rsv = 5'(ar); flush = fl;
    if (chk) begin
      cnt = 0;
      foreach (pend_m[i]) cnt += int'(pend_m[i]);
      e.d0   = 8'(rd_m(a0, wr, ai, di));
      e.d1   = 8'(rd_m(a1, wr, ai, di));
      e.r0   = !pend_m[a0] || (wr && ai == a0);
      e.r1   = !pend_m[a1] || (wr && ai == a1);
      e.waw  = rs && ar != 0 && pend_m[ar] && !(wr && ai == ar);
      e.busy = 6'(cnt);
      expq.push_back(e);
    end
    if (rst) begin
      foreach (mem_m[i]) begin mem_m[i] = 0; pend_m[i] = 0; end
    end else begin
      if (wr && ai != 0) begin mem_m[ai] = di; pend_m[ai] = 0; end
      if (fl) foreach (pend_m[i]) pend_m[i] = 0;
      if (rs && ar != 0) pend_m[ar] = 1;
    end
  endtask

  task automatic idle(input int a0, input int a1);
    step(0, 0, 0, 0, a0, a1, 0, 0, 0);
  endtask

  initial begin
    reset = 1; write = 0; addr_in = 0; data_in = 0; addr_out = '0;
    reserve = 0; addr_rsv = 0; flush = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 31);

    // Fill regs 1..31, reading (n, n-1) so port 0 bypasses and port 1 hits storage.
    for (int n = 1; n < 32; n++) step(0, 1, n, 'h10 + n, n, n - 1, 0, 0, 0);
    for (int n = 1; n < 32; n++) idle(n, n - 1);
    step(0, 1, 0, 'hFF, 0, 0, 0, 0, 0);
    idle(0, 0);

    step(0, 1, 7, 'hA5, 7, 6, 0, 0, 0);
    idle(7, 6);

    step(0, 0, 0, 0, 3, 3, 1, 3, 0);
    idle(0, 3);
    step(0, 1, 3, 'h42, 0, 3, 0, 0, 0);
    idle(0, 3);

    step(0, 0, 0, 0, 5, 5, 1, 5, 0);
    step(0, 0, 0, 0, 5, 5, 1, 5, 0);
    step(0, 1, 5, 'h5C, 5, 4, 1, 5, 0);
    idle(5, 4);
    step(0, 1, 5, 'h5D, 5, 4, 0, 0, 0);

    for (int n = 1; n <= 10; n++) step(0, 0, 0, 0, n, n - 1, 1, n, 0);
    idle(10, 1);
    step(0, 0, 0, 0, 12, 1, 1, 12, 1);
    for (int n = 0; n < 16; n++) idle(n, 12);

    for (int n = 20; n < 26; n++) step(0, 0, 0, 0, n, 0, 1, n, 0);
    step(1, 1, 21, 'h77, 21, 22, 1, 23, 0);
    for (int n = 16; n < 32; n++) idle(n, n - 16);

    // Reserve of register 0 must be ignored.
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(0, 0);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)),
           $urandom_range(0, 39) == 0);
    end

    @(posedge clk);
    #1;
    write = 0; reserve = 0; flush = 0; reset = 0;
    for (int t = 0; t < 10 && expq.size() > 0; t++) @(posedge clk);
    if (expq.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
